// File: rtl/bp_tlb_asid.sv
// bp_tlb_asid: fully associative, ASID-tagged TLB with a one-cycle lookup.
// A lookup miss parks the block in MISS until a matching fill or any flush.
//   clk_i, reset_i                 clock, async active-high reset
//   translation_en_i               0 = passthrough, 1 = lookup
//   asid_i                         current ASID for lookups
//   r_v_i / r_vtag_i / ready_o     lookup request, tag, ready
//   w_v_i / w_vtag_i / w_asid_i / w_global_i / w_entry_i   fill port
//   flush_v_i / flush_mode_i / flush_vtag_i / flush_asid_i invalidate port
//   v_o / miss_v_o / miss_vtag_o / entry_o                 registered results
module bp_tlb_asid #(
  parameter int unsigned els_p        = 8,
  parameter int unsigned vtag_width_p = 27,
  parameter int unsigned ptag_width_p = 28,
  parameter int unsigned asid_width_p = 9
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      translation_en_i,
  input  logic [asid_width_p-1:0]   asid_i,
  input  logic                      r_v_i,
  input  logic [vtag_width_p-1:0]   r_vtag_i,
  output logic                      ready_o,
  input  logic                      w_v_i,
  input  logic [vtag_width_p-1:0]   w_vtag_i,
  input  logic [asid_width_p-1:0]   w_asid_i,
  input  logic                      w_global_i,
  input  logic [ptag_width_p+3:0]   w_entry_i,
  input  logic                      flush_v_i,
  input  logic [1:0]                flush_mode_i,
  input  logic [vtag_width_p-1:0]   flush_vtag_i,
  input  logic [asid_width_p-1:0]   flush_asid_i,
  output logic                      v_o,
  output logic                      miss_v_o,
  output logic [vtag_width_p-1:0]   miss_vtag_o,
  output logic [ptag_width_p+3:0]   entry_o
);

  localparam int unsigned entry_w_lp = ptag_width_p + 4;
  localparam int unsigned idx_w_lp   = $clog2(els_p);

  typedef enum logic {S_READY = 1'b0, S_MISS = 1'b1} state_e;

  state_e                    r_state;
  logic                      r_ready;
  logic                      r_v;
  logic                      r_miss_v;
  logic [vtag_width_p-1:0]   r_miss_vtag;
  logic [entry_w_lp-1:0]     r_entry_o;
  logic [idx_w_lp-1:0]       r_victim;
  logic [els_p-1:0]          r_valid;
  logic [els_p-1:0]          r_glob;
  logic [vtag_width_p-1:0]   r_tag   [els_p];
  logic [asid_width_p-1:0]   r_asid  [els_p];
  logic [entry_w_lp-1:0]     r_entry [els_p];

  logic                      w_hit;
  logic [idx_w_lp-1:0]       w_hit_idx;
  logic                      w_same;
  logic [idx_w_lp-1:0]       w_same_idx;
  logic                      w_free;
  logic [idx_w_lp-1:0]       w_free_idx;
  logic [idx_w_lp-1:0]       w_fill_idx;
  logic                      w_use_victim;
  logic [els_p-1:0]          w_wr;
  logic [els_p-1:0]          w_tm;
  logic [els_p-1:0]          w_am;
  logic [els_p-1:0]          w_gl;
  logic [els_p-1:0]          w_kill;
  logic [els_p-1:0]          w_valid_n;

  assign ready_o     = r_ready;
  assign v_o         = r_v;
  assign miss_v_o    = r_miss_v;
  assign miss_vtag_o = r_miss_vtag;
  assign entry_o     = r_entry_o;

  // Lookup match; descending scan so the lowest matching index wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = els_p - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_tag[i] == r_vtag_i) && (r_glob[i] || (r_asid[i] == asid_i))) begin
        w_hit     = 1'b1;
        w_hit_idx = idx_w_lp'(i);
      end
    end
  end

  // Fill placement: same-tag/same-ASID (or both global) entry, else lowest free, else victim.
  always_comb begin
    w_same     = 1'b0;
    w_same_idx = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = els_p - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_tag[i] == w_vtag_i) &&
          ((r_glob[i] && w_global_i) || (!r_glob[i] && !w_global_i && (r_asid[i] == w_asid_i)))) begin
        w_same     = 1'b1;
        w_same_idx = idx_w_lp'(i);
      end
      if (!r_valid[i]) begin
        w_free     = 1'b1;
        w_free_idx = idx_w_lp'(i);
      end
    end
    w_fill_idx   = w_same ? w_same_idx : (w_free ? w_free_idx : r_victim);
    w_use_victim = w_v_i && !w_same && !w_free;
    w_wr         = '0;
    if (w_v_i) w_wr[w_fill_idx] = 1'b1;
  end

  // Flush is evaluated against post-fill contents so a same-cycle matching fill is discarded.
  always_comb begin
    for (int i = 0; i < els_p; i++) begin
      w_tm[i] = w_wr[i] ? (w_vtag_i == flush_vtag_i) : (r_tag[i] == flush_vtag_i);
      w_am[i] = w_wr[i] ? (w_asid_i == flush_asid_i) : (r_asid[i] == flush_asid_i);
      w_gl[i] = w_wr[i] ? w_global_i : r_glob[i];
    end
    w_kill = '0;
    if (flush_v_i) begin
      case (flush_mode_i)
        2'd0:    w_kill = '1;
        2'd1:    w_kill = w_tm;
        2'd2:    w_kill = w_am & ~w_gl;
        default: w_kill = w_tm & w_am & ~w_gl;
      endcase
    end
    w_valid_n = (r_valid | w_wr) & ~w_kill;
  end

  // Entry payload storage; contents are qualified by r_valid so no reset is needed.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < els_p; i++) begin
      if (w_wr[i]) begin
        r_tag[i]   <= w_vtag_i;
        r_asid[i]  <= w_asid_i;
        r_glob[i]  <= w_global_i;
        r_entry[i] <= w_entry_i;
      end
    end
  end

  // Valid bits, victim pointer, READY/MISS state and registered results.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= S_READY;
      r_ready     <= 1'b1;
      r_v         <= 1'b0;
      r_miss_v    <= 1'b0;
      r_miss_vtag <= '0;
      r_entry_o   <= '0;
      r_victim    <= '0;
      r_valid     <= '0;
    end else begin
      r_valid  <= w_valid_n;
      r_v      <= 1'b0;
      r_miss_v <= 1'b0;
      if (w_use_victim) r_victim <= idx_w_lp'(r_victim + 1'b1);
      case (r_state)
        S_READY: begin
          if (r_v_i) begin
            if (!translation_en_i) begin
              r_v       <= 1'b1;
              r_entry_o <= {4'b0111, ptag_width_p'(r_vtag_i)};
            end else if (w_hit) begin
              r_v       <= 1'b1;
              r_entry_o <= r_entry[w_hit_idx];
            end else begin
              r_miss_v    <= 1'b1;
              r_miss_vtag <= r_vtag_i;
              r_state     <= S_MISS;
              r_ready     <= 1'b0;
            end
          end
        end
        default: begin
          if (flush_v_i || (w_v_i && (w_vtag_i == r_miss_vtag))) begin
            r_state <= S_READY;
            r_ready <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bp_tlb_asid.sv
// tb_bp_tlb_asid: scoreboard bench for bp_tlb_asid at default parameters.
module tb_bp_tlb_asid;

  localparam int unsigned VT = 27;
  localparam int unsigned PT = 28;
  localparam int unsigned AW = 9;
  localparam int unsigned EW = PT + 4;
  localparam logic [VT-1:0] NOTAG = '1;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          translation_en_i = 1'b0;
  logic [AW-1:0] asid_i = '0;
  logic          r_v_i = 1'b0;
  logic [VT-1:0] r_vtag_i = '0;
  logic          ready_o;
  logic          w_v_i = 1'b0;
  logic [VT-1:0] w_vtag_i = '0;
  logic [AW-1:0] w_asid_i = '0;
  logic          w_global_i = 1'b0;
  logic [EW-1:0] w_entry_i = '0;
  logic          flush_v_i = 1'b0;
  logic [1:0]    flush_mode_i = '0;
  logic [VT-1:0] flush_vtag_i = '0;
  logic [AW-1:0] flush_asid_i = '0;
  logic          v_o;
  logic          miss_v_o;
  logic [VT-1:0] miss_vtag_o;
  logic [EW-1:0] entry_o;

  bp_tlb_asid dut (
    .clk_i(clk_i), .reset_i(reset_i), .translation_en_i(translation_en_i), .asid_i(asid_i),
    .r_v_i(r_v_i), .r_vtag_i(r_vtag_i), .ready_o(ready_o),
    .w_v_i(w_v_i), .w_vtag_i(w_vtag_i), .w_asid_i(w_asid_i), .w_global_i(w_global_i),
    .w_entry_i(w_entry_i), .flush_v_i(flush_v_i), .flush_mode_i(flush_mode_i),
    .flush_vtag_i(flush_vtag_i), .flush_asid_i(flush_asid_i),
    .v_o(v_o), .miss_v_o(miss_v_o), .miss_vtag_o(miss_vtag_o), .entry_o(entry_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          v;
    logic          m;
    logic [EW-1:0] e;
    logic [VT-1:0] mt;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic [3:0] perm, input logic [PT-1:0] ptag);
    return {perm, ptag};
  endfunction

  // Pop one expectation per cycle in which a lookup result is due; otherwise outputs must be idle.
  always @(posedge clk_i) begin
    #1;
    if (!reset_i) begin
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        check_eq("v_o", 64'(v_o), 64'(mon_e.v));
        check_eq("miss_v_o", 64'(miss_v_o), 64'(mon_e.m));
        if (mon_e.v) check_eq("entry_o", 64'(entry_o), 64'(mon_e.e));
        if (mon_e.m) begin
          check_eq("miss_vtag_o", 64'(miss_vtag_o), 64'(mon_e.mt));
          check_eq("ready_in_miss", 64'(ready_o), 64'h0);
        end
      end else begin
        check_eq("idle_v", 64'(v_o), 64'h0);
        check_eq("idle_miss", 64'(miss_v_o), 64'h0);
      end
    end
  end

  task automatic lookup(input logic en, input logic [VT-1:0] vt, input logic [AW-1:0] as,
                        input logic ev, input logic em, input logic [EW-1:0] ee);
    exp_t x;
    @(negedge clk_i);
    translation_en_i = en;
    r_vtag_i = vt;
    asid_i = as;
    r_v_i = 1'b1;
    x.v = ev; x.m = em; x.e = ee; x.mt = vt;
    q.push_back(x);
    @(negedge clk_i);
    r_v_i = 1'b0;
  endtask

  task automatic fill(input logic [VT-1:0] vt, input logic [AW-1:0] as, input logic gl,
                      input logic [EW-1:0] ent);
    @(negedge clk_i);
    w_v_i = 1'b1; w_vtag_i = vt; w_asid_i = as; w_global_i = gl; w_entry_i = ent;
    @(negedge clk_i);
    w_v_i = 1'b0;
  endtask

  task automatic flush(input logic [1:0] mode, input logic [VT-1:0] vt, input logic [AW-1:0] as);
    @(negedge clk_i);
    flush_v_i = 1'b1; flush_mode_i = mode; flush_vtag_i = vt; flush_asid_i = as;
    @(negedge clk_i);
    flush_v_i = 1'b0;
  endtask

  // Expect a miss, then leave MISS with a flush that matches no stored tag.
  task automatic miss_recover(input string tag, input logic [VT-1:0] vt, input logic [AW-1:0] as);
    lookup(1'b1, vt, as, 1'b0, 1'b1, '0);
    check_eq({tag, "_ready0"}, 64'(ready_o), 64'h0);
    flush(2'd1, NOTAG, '0);
    check_eq({tag, "_ready1"}, 64'(ready_o), 64'h1);
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk_i);
    check_eq("rst_ready", 64'(ready_o), 64'h1);
    check_eq("rst_v", 64'(v_o), 64'h0);
    check_eq("rst_miss", 64'(miss_v_o), 64'h0);
    check_eq("rst_mvtag", 64'(miss_vtag_o), 64'h0);
    check_eq("rst_entry", 64'(entry_o), 64'h0);
    reset_i = 1'b0;

    // Passthrough
    lookup(1'b0, 27'h5, '0, 1'b1, 1'b0, mk(4'b0111, 28'h5));
    check_eq("pass_ready", 64'(ready_o), 64'h1);
    lookup(1'b0, 27'h7ABCDEF, '0, 1'b1, 1'b0, mk(4'b0111, 28'h7ABCDEF));

    // Miss, ignored request while in MISS, matching fill, then hit
    lookup(1'b1, 27'h123, '0, 1'b0, 1'b1, '0);
    lookup(1'b1, 27'h123, '0, 1'b0, 1'b0, '0);
    check_eq("miss_hold_tag", 64'(miss_vtag_o), 64'h123);
    fill(27'h999, '0, 1'b0, mk(4'b0001, 28'h999));
    check_eq("nonmatch_fill_ready", 64'(ready_o), 64'h0);
    fill(27'h123, '0, 1'b0, mk(4'b1111, 28'h456));
    check_eq("fill_ready", 64'(ready_o), 64'h1);
    lookup(1'b1, 27'h123, '0, 1'b1, 1'b0, mk(4'b1111, 28'h456));

    // Flush all
    flush(2'd0, '0, '0);
    miss_recover("flush_all", 27'h123, '0);

    // ASID flush spares global entries
    fill(27'h10, 9'd3, 1'b0, mk(4'b0011, 28'h1010));
    fill(27'h20, 9'd3, 1'b1, mk(4'b0101, 28'h2020));
    lookup(1'b1, 27'h10, 9'd3, 1'b1, 1'b0, mk(4'b0011, 28'h1010));
    miss_recover("asid_mismatch", 27'h10, 9'd7);
    flush(2'd2, '0, 9'd3);
    lookup(1'b1, 27'h20, 9'd7, 1'b1, 1'b0, mk(4'b0101, 28'h2020));
    miss_recover("asid_flushed", 27'h10, 9'd3);

    // Same-cycle fill and matching vtag flush
    @(negedge clk_i);
    w_v_i = 1'b1; w_vtag_i = 27'h30; w_asid_i = '0; w_global_i = 1'b0; w_entry_i = mk(4'b1001, 28'h3030);
    flush_v_i = 1'b1; flush_mode_i = 2'd1; flush_vtag_i = 27'h30; flush_asid_i = '0;
    @(negedge clk_i);
    w_v_i = 1'b0; flush_v_i = 1'b0;
    miss_recover("fill_flush", 27'h30, '0);

    // Refill of the same tag/ASID overwrites in place
    fill(27'h40, 9'd1, 1'b0, mk(4'b0001, 28'hAAA));
    fill(27'h40, 9'd1, 1'b0, mk(4'b0010, 28'hBBB));
    lookup(1'b1, 27'h40, 9'd1, 1'b1, 1'b0, mk(4'b0010, 28'hBBB));

    // Flush by vtag and ASID
    fill(27'h50, 9'd5, 1'b0, mk(4'b0100, 28'h5005));
    fill(27'h50, 9'd6, 1'b0, mk(4'b1000, 28'h5006));
    flush(2'd3, 27'h50, 9'd5);
    lookup(1'b1, 27'h50, 9'd6, 1'b1, 1'b0, mk(4'b1000, 28'h5006));
    miss_recover("mode3", 27'h50, 9'd5);

    // Victim replacement: 9th fill takes index 0, 10th takes index 1
    flush(2'd0, '0, '0);
    for (int i = 0; i < 10; i++)
      fill(VT'(27'h100 + i), '0, 1'b0, mk(4'b0001, PT'(28'h1100 + i)));
    lookup(1'b1, 27'h108, '0, 1'b1, 1'b0, mk(4'b0001, 28'h1108));
    lookup(1'b1, 27'h109, '0, 1'b1, 1'b0, mk(4'b0001, 28'h1109));
    lookup(1'b1, 27'h102, '0, 1'b1, 1'b0, mk(4'b0001, 28'h1102));
    lookup(1'b1, 27'h107, '0, 1'b1, 1'b0, mk(4'b0001, 28'h1107));
    miss_recover("victim0", 27'h100, '0);
    miss_recover("victim1", 27'h101, '0);

    // Asynchronous reset while in MISS
    lookup(1'b1, 27'h77, '0, 1'b0, 1'b1, '0);
    @(posedge clk_i);
    #2;
    reset_i = 1'b1;
    #1;
    check_eq("arst_ready", 64'(ready_o), 64'h1);
    check_eq("arst_v", 64'(v_o), 64'h0);
    check_eq("arst_miss", 64'(miss_v_o), 64'h0);
    check_eq("arst_mvtag", 64'(miss_vtag_o), 64'h0);
    @(negedge clk_i);
    reset_i = 1'b0;
    miss_recover("post_rst", 27'h108, '0);

    repeat (3) @(negedge clk_i);
    check_eq("queue_drained", 64'(q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
